// File: rtl/sipo_rx_if.sv
// ============================================================================
//  sipo_rx_if : serial-in / parallel-out receive bus bundle
//  Rev 1.0
// ============================================================================
`default_nettype none

interface sipo_rx_if #(
    parameter int WIDTH = 16
);
    logic             in;
    logic             in_start;
    logic             in_last;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             frame_err;
    logic             overrun;

    // master drives the serial stream and consumes the word; slave is the receiver
    modport master (
        output in, in_start, in_last, out_ready,
        input  out, out_valid, frame_err, overrun
    );

    modport slave (
        input  in, in_start, in_last, out_ready,
        output out, out_valid, frame_err, overrun
    );
endinterface

`default_nettype wire

// File: rtl/sipo_rx.sv
// ============================================================================
//  sipo_rx : framed LSB-first serial receiver with a one-word holding register
//  Rev 1.0
// ============================================================================
`default_nettype none

module sipo_rx #(
    parameter int WIDTH = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sipo_rx_if.slave    bus
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             w_done;
    logic [WIDTH-1:0] w_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        frame_err_d = 1'b0;
        w_done      = 1'b0;
        w_word      = {bus.in, sr_q[WIDTH-2:0]};

        unique case (state_q)
            IDLE: begin
                if (bus.in_start) begin
                    if (bus.in_last) begin
                        frame_err_d = 1'b1;
                    end else begin
                        sr_d    = '0;
                        sr_d[0] = bus.in;
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // a fresh start always wins: the partial frame is abandoned
                if (bus.in_start) begin
                    frame_err_d = 1'b1;
                    sr_d        = '0;
                    sr_d[0]     = bus.in;
                    cnt_d       = CW'(1);
                end else if (cnt_q == LAST_IDX) begin
                    w_done      = bus.in_last;
                    frame_err_d = ~bus.in_last;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (bus.in_last) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    sr_d[cnt_q] = bus.in;
                    cnt_d       = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A consumer handshake in the completion cycle frees the slot for the new word
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        if (w_done) begin
            if (out_valid_q && !bus.out_ready) begin
                overrun_d = 1'b1;
            end else begin
                out_d       = w_word;
                out_valid_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx.sv
// ============================================================================
//  tb_sipo_rx : randomized scoreboard bench for sipo_rx against a frame model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_sipo_rx;
    localparam int W = 16;

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
        logic         e;
        logic         o;
    } exp_t;

    logic clk;
    logic rst;
    sipo_rx_if #(.WIDTH(W)) bus ();

    sipo_rx #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // Reference model: the bits of the frame in progress are kept as a list
    bit           m_bits[$];
    bit           m_active;
    bit           m_hv;
    logic [W-1:0] m_hw;

    function automatic void model_reset();
        m_bits.delete();
        m_active = 1'b0;
        m_hv     = 1'b0;
        m_hw     = '0;
    endfunction

    function automatic exp_t model_step(logic b, logic st, logic ls, logic rdy);
        exp_t         e;
        bit           done;
        logic [W-1:0] word;
        e    = '0;
        done = 1'b0;
        word = '0;
        if (st) begin
            if (!m_active && ls) begin
                e.e = 1'b1;
            end else begin
                e.e      = m_active;
                m_bits   = {b};
                m_active = 1'b1;
            end
        end else if (m_active) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                m_active = 1'b0;
                if (ls) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) word[i] = m_bits[i];
                end else begin
                    e.e = 1'b1;
                end
            end else if (ls) begin
                e.e      = 1'b1;
                m_active = 1'b0;
            end
        end
        if (done) begin
            if (m_hv && !rdy) begin
                e.o = 1'b1;
            end else begin
                m_hw = word;
                m_hv = 1'b1;
            end
        end else if (m_hv && rdy) begin
            m_hv = 1'b0;
        end
        e.v = m_hv;
        e.d = m_hw;
        return e;
    endfunction

    task automatic cyc(input logic b, input logic st, input logic ls, input logic rdy);
        @(negedge clk);
        rst           = 1'b0;
        bus.in        = b;
        bus.in_start  = st;
        bus.in_last   = ls;
        bus.out_ready = rdy;
        exp_q.push_back(model_step(b, st, ls, rdy));
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst           = 1'b1;
            bus.in        = 1'($urandom);
            bus.in_start  = 1'($urandom);
            bus.in_last   = 1'($urandom);
            bus.out_ready = 1'($urandom);
            model_reset();
            exp_q.push_back('0);
        end
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int first, input int n,
                             input logic rdy, input logic rdy_last, input logic mark_last);
        for (int i = first; i < first + n; i++)
            cyc(w[i], i == first, mark_last && (i == first + n - 1),
                (i == first + n - 1) ? rdy_last : rdy);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic rdy, input logic rdy_last);
        send_bits(w, 0, W, rdy, rdy_last, 1'b1);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'($urandom), 1'b0, 1'b0, rdy);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic look(input string name, input logic [W-1:0] word, input logic valid);
        @(posedge clk);
        #2;
        chk({name, "_out"}, bus.out, word);
        chk({name, "_valid"}, {{(W-1){1'b0}}, bus.out_valid}, {{(W-1){1'b0}}, valid});
    endtask

    // Monitor: one expected snapshot per clock edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid", {{(W-1){1'b0}}, bus.out_valid}, {{(W-1){1'b0}}, e.v});
                chk("out", bus.out, e.d);
                chk("frame_err", {{(W-1){1'b0}}, bus.frame_err}, {{(W-1){1'b0}}, e.e});
                chk("overrun", {{(W-1){1'b0}}, bus.overrun}, {{(W-1){1'b0}}, e.o});
            end
        end
    end

    initial begin
        int           kind;
        int           pos;
        logic [W-1:0] w;
        rst           = 1'b1;
        bus.in        = 1'b0;
        bus.in_start  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        reset_cycles(3);
        idle(2, 1'b1);

        send_frame(16'hA5C3, 1'b1, 1'b1);
        look("basic", 16'hA5C3, 1'b1);
        idle(2, 1'b1);

        send_frame(16'hA5C3, 1'b0, 1'b0);
        send_frame(16'h1234, 1'b0, 1'b0);
        idle(2, 1'b0);
        look("overrun_hold", 16'hA5C3, 1'b1);
        idle(2, 1'b1);

        send_frame(16'h00FF, 1'b0, 1'b0);
        idle(1, 1'b0);
        send_frame(16'h1234, 1'b0, 1'b1);
        look("replace", 16'h1234, 1'b1);
        idle(1, 1'b1);

        send_bits(16'h5555, 0, 11, 1'b1, 1'b1, 1'b1);
        idle(1, 1'b1);
        send_frame(16'hBEEF, 1'b1, 1'b1);
        look("after_err", 16'hBEEF, 1'b1);
        idle(1, 1'b1);

        send_bits(16'h0000, 0, 6, 1'b1, 1'b1, 1'b0);
        send_frame(16'hFFFF, 1'b1, 1'b1);
        look("restart", 16'hFFFF, 1'b1);
        idle(1, 1'b1);

        send_bits(16'hFFFF, 0, 8, 1'b1, 1'b1, 1'b0);
        reset_cycles(2);
        send_frame(16'h0001, 1'b0, 1'b0);
        look("post_reset", 16'h0001, 1'b1);
        idle(2, 1'b1);

        for (int f = 0; f < 250; f++) begin
            w    = W'($urandom);
            kind = int'($urandom_range(0, 9));
            pos  = int'($urandom_range(1, W - 2));
            case (kind)
                5: send_bits(w, 0, pos + 1, 1'($urandom), 1'($urandom), 1'b1);
                6: begin
                    send_bits(w, 0, pos, 1'($urandom), 1'($urandom), 1'b0);
                    send_frame(w, 1'($urandom), 1'($urandom));
                end
                7: begin
                    send_bits(w, 0, pos, 1'($urandom), 1'($urandom), 1'b0);
                    reset_cycles(int'($urandom_range(1, 2)));
                end
                8: send_bits(w, 0, W, 1'($urandom), 1'($urandom), 1'b0);
                9: cyc(1'($urandom), 1'b1, 1'b1, 1'($urandom));
                default: send_frame(w, 1'($urandom), 1'($urandom));
            endcase
            for (int g = int'($urandom_range(0, 2)); g > 0; g--)
                cyc(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
        end

        idle(3, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("drain", W'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter: WIDTH, default 16, frame length in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in  input  1  serial data, LSB first, one bit per clock.
REQ-005 Port: in_start  input  1  high in the cycle that carries bit 0 of a frame.
REQ-006 Port: in_last  input  1  high in the cycle that carries bit WIDTH-1; driven by the transmitter's done flag.
REQ-007 Port: out  output  WIDTH  received parallel word (holding register).
REQ-008 Port: out_valid  output  1  holding register contains an unconsumed word.
REQ-009 Port: out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high at a rising edge.
REQ-010 Port: frame_err  output  1  one-cycle pulse on a framing violation.
REQ-011 Port: overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT, plus a bit counter cnt (clog2(WIDTH) bits) and a WIDTH-bit shift register sr.
REQ-013 In IDLE with in_start=1 and in_last=0, the block SHALL sample in into sr bit 0, set cnt=1, and go to SHIFT.
REQ-014 In IDLE, the block SHALL ignore in and in_last when in_start=0.
REQ-015 In IDLE with in_start=1 and in_last=1, the block SHALL pulse frame_err and stay in IDLE.
REQ-016 In SHIFT, each edge SHALL store in at sr bit cnt and increment cnt.
REQ-017 At cnt=WIDTH-1 with in_last=1 and in_start=0, the frame is complete: the full word {in, sr[WIDTH-2:0]} SHALL go to the holding path, and the block SHALL return to IDLE with cnt=0.
REQ-018 At cnt=WIDTH-1 with in_last=0, the block SHALL pulse frame_err, discard the frame, and go to IDLE.
REQ-019 In SHIFT with cnt<WIDTH-1 and in_last=1, the block SHALL pulse frame_err, discard the frame, and go to IDLE.
REQ-020 In SHIFT with in_start=1 (any cnt), the block SHALL pulse frame_err, discard the partial frame, treat the current bit as bit 0 of a new frame (cnt=1), and stay in SHIFT; this rule has priority over REQ-017 to REQ-019.
REQ-021 Latency: out and out_valid SHALL update on the same edge that samples bit WIDTH-1, so they are visible in the cycle after in_last.
REQ-022 Holding path on frame completion:
- if out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: load out and set out_valid=1, with no overrun.
- if out_valid=1 and out_ready=0: keep the old out, drop the new word, and pulse overrun.
REQ-023 Consumption without completion: out_valid=1 and out_ready=1 SHALL clear out_valid; out keeps its last value.
REQ-024 A back-to-back frame whose in_start arrives in the cycle immediately after in_last SHALL be received without loss.
REQ-025 frame_err and overrun SHALL be registered, high for exactly one cycle per event, and may assert in the same cycle.

Reset
REQ-026 While rst is high, the block SHALL hold: state=IDLE, cnt=0, sr=0, out=0, out_valid=0, frame_err=0, overrun=0.
REQ-027 When rst asserts mid-frame, the block SHALL discard the partial frame with no frame_err or overrun pulse.
REQ-028 After rst deasserts, the first rising edge with in_start=1 SHALL begin a new frame.

Verification (WIDTH=16)
REQ-029 Send 0xA5C3 LSB first, in_start on bit 0, in_last on bit 15, out_ready=1 -> out=16'hA5C3 and out_valid high in the cycle after in_last, cleared one cycle later.
REQ-030 out_ready=0; receive 0xA5C3, then 0x1234 -> overrun pulses 1 cycle after 0x1234's in_last and out stays 0xA5C3; raise out_ready -> out_valid drops.
REQ-031 out_valid=1 holding 0x00FF, out_ready=1 in the completion cycle of 0x1234 -> out=0x1234, out_valid stays 1, overrun=0.
REQ-032 Raise in_last on bit 10 -> frame_err 1 cycle, no out_valid; a following frame 0xBEEF -> out=0xBEEF.
REQ-033 Raise in_start again on bit 6, then send a full 0xFFFF frame from that point -> frame_err 1 cycle, out=0xFFFF.
REQ-034 Assert rst during bit 8, release, send 0x0001 -> all outputs 0 during reset, no error pulses, then out=0x0001 with out_valid=1.
